// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative signed/unsigned multiply/divide engine with {hi, lo} result
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic                 dbz_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;

    logic                 in_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;
    logic [WIDTH-1:0]     fin_hi, fin_lo;
    logic [2*WIDTH-1:0]   final_res;

    // op bit 0 clear means signed; bit 1 set means divide
    always_comb begin
        in_signed = ~op_i[0];
        a_neg     = in_signed & opdata1_i[WIDTH-1];
        b_neg     = in_signed & opdata2_i[WIDTH-1];
        a_mag     = a_neg ? -opdata1_i : opdata1_i;
        b_mag     = b_neg ? -opdata2_i : opdata2_i;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

        step_next = op_q[1] ? div_next : mul_next;

        fin_hi    = neg_hi_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
        fin_lo    = neg_lo_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        if (op_q[1]) begin
            final_res = {fin_hi, fin_lo};
        end else begin
            final_res = neg_lo_q ? -step_next : step_next;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    op_d     = op_i;
                    opb_d    = b_mag;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    if (op_i[1] && (opdata2_i == '0)) begin
                        state_d  = DONE;
                        dbz_d    = 1'b1;
                        result_d = {opdata1_i, {WIDTH{1'b1}}};
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign ready_o  = (state_q == DONE) && !annul_i;
    assign dbz_o    = dbz_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8
module tb_muldiv_iter;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    exp_t        q32[$];
    exp_t        q8[$];

    logic        start32, annul32, busy32, ready32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic [63:0] res32;

    logic        start8, annul8, busy8, ready8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
        .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
        .busy_o(busy32), .ready_o(ready32), .dbz_o(dbz32), .result_o(res32)
    );

    muldiv_iter #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
        .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
        .busy_o(busy8), .ready_o(ready8), .dbz_o(dbz8), .result_o(res8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on sign-extended operands, returns {dbz, {hi, lo}}
    function automatic logic [64:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, m2, ua, ub, lo, hi, r;
        longint sa, sb, p, q, rm;
        m  = (64'd1 << w) - 1;
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 1);
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        if (op[1] && ub == 0) return {1'b1, (ua << w) | m};
        case (op)
            2'b00: begin p = sa * sb; r = longint'(p); r = r & m2; end
            2'b01: r = (ua * ub) & m2;
            2'b10: begin
                q = sa / sb; rm = sa % sb;
                lo = q; hi = rm;
                r = ((hi & m) << w) | (lo & m);
            end
            default: r = ((ua % ub) << w) | (ua / ub);
        endcase
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && ready32) begin
            if (q32.size() == 0) begin
                total++;
                $display("FAIL w32 unexpected ready: got 1 expected 0");
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("w32 result", res32, e.res);
                chk("w32 dbz", 64'(dbz32), 64'(e.dbz));
                chk("w32 latency", 64'(cyc - e.issue), 64'(e.lat));
            end
        end
        if (!rst && ready8) begin
            if (q8.size() == 0) begin
                total++;
                $display("FAIL w8 unexpected ready: got 1 expected 0");
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8 result", 64'(res8), e.res);
                chk("w8 dbz", 64'(dbz8), 64'(e.dbz));
                chk("w8 latency", 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        exp_t        e;
        int          n;
        m = model(32, op, a, b);
        e.res = m[63:0]; e.dbz = m[64]; e.lat = m[64] ? 1 : 33; e.issue = cyc;
        q32.push_back(e);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        n = 0;
        while (busy32 && n < 100) begin n++; @(negedge clk); end
        chk("w32 busy cycles", 64'(n), 64'(e.lat));
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [64:0] m;
        exp_t        e;
        int          n;
        m = model(8, op, {24'd0, a}, {24'd0, b});
        e.res = m[63:0]; e.dbz = m[64]; e.lat = m[64] ? 1 : 9; e.issue = cyc;
        q8.push_back(e);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (busy8 && n < 100) begin n++; @(negedge clk); end
        chk("w8 busy cycles", 64'(n), 64'(e.lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] prev;
        rst = 1'b1;
        start32 = 0; annul32 = 0; op32 = 0; a32 = 0; b32 = 0;
        start8 = 0; annul8 = 0; op8 = 0; a8 = 0; b8 = 0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset ready", 64'(ready32), 64'd0);
        chk("reset dbz", 64'(dbz32), 64'd0);
        chk("reset result", res32, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run32(2'b00, 32'hFFFF_FFFD, 32'd7);
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run32(2'b10, 32'hFFFF_FFF9, 32'd2);
        run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run32(2'b11, 32'd100, 32'd0);
        run32(2'b11, 32'd100, 32'd7);

        // annul 10 cycles into a multiply
        prev = res32;
        start32 = 1'b1; op32 = 2'b00; a32 = $urandom; b32 = $urandom;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        annul32 = 1'b1;
        @(negedge clk);
        annul32 = 1'b0;
        chk("annul busy", 64'(busy32), 64'd0);
        chk("annul result held", res32, prev);
        run32(2'b01, 32'd5, 32'd6);

        // start with annul in the same cycle is ignored
        start32 = 1'b1; annul32 = 1'b1; op32 = 2'b01; a32 = 32'd3; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0; annul32 = 1'b0;
        chk("start+annul ignored", 64'(busy32), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            if (i % 7 == 0) b = 32'hFFFF_FFFF;
            run32(2'($urandom_range(0, 3)), a, b);
        end

        // reset in the middle of a divide
        start32 = 1'b1; op32 = 2'b10; a32 = $urandom; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-op reset busy", 64'(busy32), 64'd0);
        chk("mid-op reset ready", 64'(ready32), 64'd0);
        chk("mid-op reset dbz", 64'(dbz32), 64'd0);
        chk("mid-op reset result", res32, 64'd0);
        @(negedge clk);
        run32(2'b10, 32'hFFFF_FF9C, 32'd7);

        run8(2'b11, 8'd200, 8'd7);
        run8(2'b00, 8'h80, 8'h80);
        run8(2'b10, 8'h80, 8'hFF);
        run8(2'b10, 8'hF9, 8'd0);
        for (int i = 0; i < 12; i++) begin
            run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        chk("w32 queue drained", 64'(q32.size()), 64'd0);
        chk("w8 queue drained", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
